// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar measurement sequencer: state codes,
// distance width and default timing parameters.
package sonar_pkg;

    localparam int LARGURA_MEDIDA = 12;
    localparam int PERIODO_PADRAO = 3000000;
    localparam int TIMEOUT_PADRAO = 2500000;
    localparam int LOG2_PADRAO    = 2;

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        ESPERA  = 4'h1,
        DISPARA = 4'h2,
        AGUARDA = 4'h3,
        ACUMULA = 4'h4,
        PUBLICA = 4'h5,
        ERRO    = 4'hF
    } estado_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-MODULO up counter with synchronous clear, count enable and a
// terminal-count flag that is high while enabled on the last value.
module contador_m #(
    parameter int MODULO  = 16,
    parameter int LARGURA = (MODULO > 1) ? $clog2(MODULO) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic limpar,
    input  logic habilitar,
    output logic fim
);

    localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(MODULO - 1);
    localparam logic [LARGURA-1:0] UM     = LARGURA'(1);

    logic [LARGURA-1:0] contagem_r;

    // Count register: clear wins over enable, wraps after the last value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem_r <= '0;
        end else if (limpar) begin
            contagem_r <= '0;
        end else if (habilitar) begin
            if (contagem_r == ULTIMO) begin
                contagem_r <= '0;
            end else begin
                contagem_r <= contagem_r + UM;
            end
        end
    end

    assign fim = habilitar && (contagem_r == ULTIMO);

endmodule

// File: rtl/sequenciador_sonar.sv
// Periodic ultrasonic measurement sequencer with timeout and optional
// averaging, enabled by defining SEQUENCIADOR_FILTRO_MEDIA_EN.
module sequenciador_sonar
    import sonar_pkg::*;
#(
    parameter int PERIODO_CICLOS = PERIODO_PADRAO,
    parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO,
    parameter int LOG2_AMOSTRAS  = LOG2_PADRAO
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ligar,
    input  logic                      pronto,
    input  logic [LARGURA_MEDIDA-1:0] medida,
    output logic                      medir,
    output logic [LARGURA_MEDIDA-1:0] media,
    output logic                      media_valida,
    output logic                      erro_timeout,
    output logic [3:0]                db_estado
);

`ifdef SEQUENCIADOR_FILTRO_MEDIA_EN
    localparam int L_EF = LOG2_AMOSTRAS;
`else
    // Without the filter every sample is published on its own.
    localparam int L_EF = LOG2_AMOSTRAS * 0;
`endif
    localparam int N_AMOSTRAS = 1 << L_EF;
    localparam int CNT_W      = L_EF + 1;
    localparam logic [CNT_W-1:0] ULTIMA_AMOSTRA = CNT_W'(N_AMOSTRAS - 1);
    localparam logic [CNT_W-1:0] UM_CNT         = CNT_W'(1);

    estado_t estado_r, proximo_s;
    logic fim_periodo_s, fim_timeout_s, aguardando_s;
    logic dispara_s, captura_s, acumula_s, publica_s, erro_s, aborta_s;
    logic [LARGURA_MEDIDA-1:0] amostra_r, media_r, resultado_s;
    logic [CNT_W-1:0]          contagem_r;
    logic medir_r, media_valida_r, erro_timeout_r;

    assign aguardando_s = (estado_r == AGUARDA);

    // The period counter's last value is PERIODO-2 so DISPARA repeats every PERIODO cycles.
    contador_m #(.MODULO(PERIODO_CICLOS - 1)) u_periodo (
        .clock     (clock),
        .reset     (reset),
        .limpar    (dispara_s),
        .habilitar (1'b1),
        .fim       (fim_periodo_s)
    );

    contador_m #(.MODULO(TIMEOUT_CICLOS)) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .limpar    (dispara_s),
        .habilitar (aguardando_s),
        .fim       (fim_timeout_s)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r <= INICIAL;
        end else begin
            estado_r <= proximo_s;
        end
    end

    // Next-state logic and per-state action strobes; ligar=0 overrides everything.
    always_comb begin
        proximo_s = estado_r;
        dispara_s = 1'b0;
        captura_s = 1'b0;
        acumula_s = 1'b0;
        publica_s = 1'b0;
        erro_s    = 1'b0;
        aborta_s  = 1'b0;
        if (!ligar) begin
            proximo_s = INICIAL;
            aborta_s  = 1'b1;
        end else begin
            case (estado_r)
                INICIAL: proximo_s = DISPARA;
                ESPERA: begin
                    if (fim_periodo_s) begin
                        proximo_s = DISPARA;
                    end else begin
                        proximo_s = ESPERA;
                    end
                end
                DISPARA: begin
                    dispara_s = 1'b1;
                    proximo_s = AGUARDA;
                end
                AGUARDA: begin
                    if (pronto) begin
                        captura_s = 1'b1;
                        proximo_s = ACUMULA;
                    end else if (fim_timeout_s) begin
                        proximo_s = ERRO;
                    end else begin
                        proximo_s = AGUARDA;
                    end
                end
                ACUMULA: begin
                    acumula_s = 1'b1;
                    if (contagem_r == ULTIMA_AMOSTRA) begin
                        proximo_s = PUBLICA;
                    end else begin
                        proximo_s = ESPERA;
                    end
                end
                PUBLICA: begin
                    publica_s = 1'b1;
                    proximo_s = ESPERA;
                end
                ERRO: begin
                    erro_s    = 1'b1;
                    proximo_s = ESPERA;
                end
                default: proximo_s = INICIAL;
            endcase
        end
    end

`ifdef SEQUENCIADOR_FILTRO_MEDIA_EN
    localparam int ACC_W = LARGURA_MEDIDA + L_EF;
    logic [ACC_W-1:0] acumulador_r;

    // Running sum; sized so N full-scale samples cannot overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acumulador_r <= '0;
        end else if (aborta_s || erro_s || publica_s) begin
            acumulador_r <= '0;
        end else if (acumula_s) begin
            acumulador_r <= acumulador_r + ACC_W'(amostra_r);
        end
    end

    assign resultado_s = LARGURA_MEDIDA'(acumulador_r >> L_EF);
`else
    assign resultado_s = amostra_r;
`endif

    // Sample capture, sample count and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            amostra_r      <= '0;
            contagem_r     <= '0;
            medir_r        <= 1'b0;
            media_r        <= '0;
            media_valida_r <= 1'b0;
            erro_timeout_r <= 1'b0;
        end else begin
            medir_r        <= dispara_s;
            media_valida_r <= publica_s;
            if (captura_s) begin
                amostra_r <= medida;
            end
            if (aborta_s || erro_s || publica_s) begin
                contagem_r <= '0;
            end else if (acumula_s) begin
                contagem_r <= contagem_r + UM_CNT;
            end
            if (erro_s) begin
                erro_timeout_r <= 1'b1;
            end else if (acumula_s) begin
                erro_timeout_r <= 1'b0;
            end
            if (publica_s) begin
                media_r <= resultado_s;
            end
        end
    end

    assign medir        = medir_r;
    assign media        = media_r;
    assign media_valida = media_valida_r;
    assign erro_timeout = erro_timeout_r;
    assign db_estado    = estado_r;

endmodule

// File: doc/sequenciador_sonar.md
SEQUENCIADOR_SONAR -- requirements
Module: sequenciador_sonar

Interface
REQ-001 Parameter PERIODO_CICLOS, default 3000000; clocks between consecutive measurement starts (60 ms at 50 MHz).
REQ-002 Parameter TIMEOUT_CICLOS, default 2500000; maximum clocks to wait for pronto after a start; SHALL be < PERIODO_CICLOS-4.
REQ-003 Parameter LOG2_AMOSTRAS, default 2; number of samples averaged is 2^LOG2_AMOSTRAS; legal range 0..4.
REQ-004 clock  input  1  single system clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 ligar  input  1  level; 1 = periodic measurement enabled.
REQ-007 pronto  input  1  one-cycle pulse from the ultrasonic interface: measurement complete.
REQ-008 medida  input  12  distance from the interface; valid in the cycle pronto=1.
REQ-009 medir  output  1  one-cycle start pulse to the ultrasonic interface.
REQ-010 media  output  12  last published distance result.
REQ-011 media_valida  output  1  one-cycle pulse when media updates.
REQ-012 erro_timeout  output  1  level; 1 after a timeout until the next accepted sample.
REQ-013 db_estado  output  4  current FSM state encoding.

Function
REQ-014 States and db_estado codes: INICIAL=0, ESPERA=1, DISPARA=2, AGUARDA=3, ACUMULA=4, PUBLICA=5, ERRO=F.
REQ-015 INICIAL: ligar=1 -> DISPARA next cycle; otherwise stay.
REQ-016 DISPARA lasts exactly one cycle, drives medir=1, reloads the period counter and clears the timeout counter, then -> AGUARDA.
REQ-017 The period counter SHALL count every cycle after DISPARA; the next DISPARA occurs exactly PERIODO_CICLOS cycles after the previous one.
REQ-018 AGUARDA: pronto=1 -> capture medida, go to ACUMULA; timeout counter reaches TIMEOUT_CICLOS with no pronto -> ERRO.
REQ-019 If pronto and timeout expiry occur in the same cycle, pronto wins: the sample is accepted.
REQ-020 ACUMULA (one cycle): accumulator += captured sample; sample count +1; erro_timeout cleared.
REQ-021 On the 2^LOG2_AMOSTRAS-th sample, go to PUBLICA; otherwise go to ESPERA.
REQ-022 PUBLICA (one cycle): media = accumulator >> LOG2_AMOSTRAS (truncating); media_valida=1; clear accumulator and count; go to ESPERA.
REQ-023 Accumulator width SHALL be 12+LOG2_AMOSTRAS bits so it never overflows.
REQ-024 ERRO (one cycle): erro_timeout set; accumulator and count cleared (partial average discarded); go to ESPERA.
REQ-025 ESPERA: period counter expiry -> DISPARA.
REQ-026 pronto outside AGUARDA SHALL be ignored.
REQ-027 ligar=0 in any state -> INICIAL next cycle. On that path: medir=0, accumulator and count cleared, media and erro_timeout retained.
REQ-028 medir and media_valida SHALL be registered outputs, glitch-free, and never high for more than one consecutive cycle.

Reset
REQ-029 reset=1 SHALL immediately force: state INICIAL, medir=0, media=0, media_valida=0, erro_timeout=0, all counters and the accumulator 0, db_estado=0.
REQ-030 After reset deasserts with ligar=1, the first medir occurs on the second rising edge.

Configuration
REQ-031 Macro SEQUENCIADOR_FILTRO_MEDIA_EN defined: averaging per REQ-020..REQ-022.
REQ-032 Macro undefined: LOG2_AMOSTRAS is treated as 0. Every accepted sample is published directly via PUBLICA (media=medida, media_valida pulse), and no accumulator is instantiated.

Structure
REQ-033 The state encodings, the 12-bit distance width constant and the default parameter values SHALL live in the shared package sonar_pkg.
REQ-034 One sub-module, contador_m (modulo counter with clear/enable/terminal-count output), SHALL be instantiated twice: once as the period counter and once as the timeout counter.

Verification
Test parameters: PERIODO_CICLOS=100, TIMEOUT_CICLOS=60, LOG2_AMOSTRAS=2, macro defined unless stated.
REQ-035 Average: ligar=1; pronto 20 cycles after each medir with medida 100, 102, 104, 107 -> one media_valida with media=103; medir pulses spaced exactly 100 cycles.
REQ-036 Timeout: no pronto after the 2nd medir -> erro_timeout=1 at cycle 61 after that medir. Next 4 samples of 50 -> media=50, erro_timeout cleared at the first accepted sample.
REQ-037 Simultaneity: pronto with medida=200 in the timeout-expiry cycle -> sample accepted, erro_timeout stays 0.
REQ-038 Abort: ligar=0 after 2 samples, then ligar=1 -> 4 fresh samples are required before media_valida; media keeps its old value meanwhile.
REQ-039 Reset mid-AGUARDA: reset pulse -> all outputs 0 immediately; a stray pronto while in INICIAL is ignored.
REQ-040 Macro undefined: medida 300 -> media=300 with media_valida on every accepted sample.
